// File: rtl/vga_console_pkg.sv
// Shared types and constants for the text-console writer: FSM states,
// control-code values and the framebuffer cell layout.
package vga_console_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CLEAR_ROW    = 2'd1,
    CLEAR_SCREEN = 2'd2
  } state_e;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_FF = 8'h0C;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] ch;
  } cell_t;

  function automatic cell_t make_cell(input logic [7:0] attr, input logic [7:0] ch);
    cell_t c;
    c.attr = attr;
    c.ch   = ch;
    return c;
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20);
  endfunction

endpackage

// File: rtl/vga_console_writer_fifo.sv
// Generic synchronous FIFO with occupancy count; pushes when full and pops
// when empty are ignored. Read data is the head entry, valid while non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vga_console_writer.sv
// Text-console front end: buffers CPU bytes, tracks the cursor, interprets
// control codes and issues single-word writes into the text framebuffer.
module vga_console_writer
  import vga_console_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 25,
  parameter int         ADDR_WIDTH = 12,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter logic [7:0] RESET_ATTR = 8'h07,
  localparam int        ROW_W      = $clog2(ROWS),
  localparam int        COL_W      = $clog2(COLS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            char_data_i,
  input  logic                  char_valid_i,
  output logic                  char_ready_o,
  input  logic [7:0]            attr_data_i,
  input  logic                  attr_we_i,
  output logic [ADDR_WIDTH-1:0] video_ram_input_addr_o,
  output logic [15:0]           video_ram_input_data_o,
  output logic                  video_ram_we_o,
  output logic [ROW_W-1:0]      cursor_row_o,
  output logic [COL_W-1:0]      cursor_col_o,
  output logic                  busy_o
);

  localparam int                    CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] COLS_A    = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(COLS - 1);

  state_e                state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_WIDTH-1:0] clr_last_q, clr_last_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  cell_t                 wr_data_q, wr_data_d;
  logic [7:0]            attr_q, attr_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;

  logic [ROW_W-1:0]      next_row;
  logic [ADDR_WIDTH-1:0] next_row_base;
  logic [ADDR_WIDTH-1:0] next_row_last;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_data;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      count_next;

  assign fifo_push = char_valid_i && ready_q && !fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (char_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Row reload is the only place a multiply appears, and it is by a constant.
  assign next_row      = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
  assign next_row_base = ADDR_WIDTH'(next_row) * COLS_A;
  assign next_row_last = next_row_base + COLS_A - ADDR_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    cur_addr_d = cur_addr_q;
    clr_addr_d = clr_addr_q;
    clr_last_d = clr_last_q;
    attr_d     = attr_we_i ? attr_data_i : attr_q;
    we_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          case (fifo_data)
            CHAR_LF: begin
              row_d      = next_row;
              cur_addr_d = next_row_base + ADDR_WIDTH'(col_q);
              clr_addr_d = next_row_base;
              clr_last_d = next_row_last;
              state_d    = CLEAR_ROW;
            end
            CHAR_CR: begin
              col_d      = '0;
              cur_addr_d = cur_addr_q - ADDR_WIDTH'(col_q);
            end
            CHAR_BS: begin
              if (col_q != '0) begin
                col_d      = col_q - COL_W'(1);
                cur_addr_d = cur_addr_q - ADDR_WIDTH'(1);
                we_d       = 1'b1;
                wr_addr_d  = cur_addr_q - ADDR_WIDTH'(1);
                wr_data_d  = make_cell(attr_q, BLANK_CHAR);
              end else begin
                we_d = 1'b0;
              end
            end
            CHAR_FF: begin
              row_d      = '0;
              col_d      = '0;
              cur_addr_d = '0;
              clr_addr_d = '0;
              clr_last_d = LAST_ADDR;
              state_d    = CLEAR_SCREEN;
            end
            default: begin
              if (is_printable(fifo_data)) begin
                we_d      = 1'b1;
                wr_addr_d = cur_addr_q;
                wr_data_d = make_cell(attr_q, fifo_data);
                if (col_q == LAST_COL) begin
                  // Wrap behaves exactly like CR+LF: no scrolling, just clear the new row.
                  col_d      = '0;
                  row_d      = next_row;
                  cur_addr_d = next_row_base;
                  clr_addr_d = next_row_base;
                  clr_last_d = next_row_last;
                  state_d    = CLEAR_ROW;
                end else begin
                  col_d      = col_q + COL_W'(1);
                  cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                end
              end else begin
                we_d = 1'b0;
              end
            end
          endcase
        end else begin
          fifo_pop = 1'b0;
        end
      end
      CLEAR_ROW, CLEAR_SCREEN: begin
        we_d      = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_data_d = make_cell(attr_q, BLANK_CHAR);
        if (clr_addr_q == clr_last_q) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    case ({fifo_push, fifo_pop})
      2'b10:   count_next = fifo_count + CNT_W'(1);
      2'b01:   count_next = fifo_count - CNT_W'(1);
      default: count_next = fifo_count;
    endcase
    ready_d = (count_next != FULL_CNT);
    // Held through the cycle carrying the final write so busy drops just after it.
    busy_d  = (state_d != IDLE) || (count_next != '0) || we_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CLEAR_SCREEN;
      row_q      <= '0;
      col_q      <= '0;
      cur_addr_q <= '0;
      clr_addr_q <= '0;
      clr_last_q <= LAST_ADDR;
      attr_q     <= RESET_ATTR;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cur_addr_q <= cur_addr_d;
      clr_addr_q <= clr_addr_d;
      clr_last_q <= clr_last_d;
      attr_q     <= attr_d;
      we_q       <= we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign char_ready_o           = ready_q;
  assign video_ram_input_addr_o = wr_addr_q;
  assign video_ram_input_data_o = wr_data_q;
  assign video_ram_we_o         = we_q;
  assign cursor_row_o           = row_q;
  assign cursor_col_o           = col_q;
  assign busy_o                 = busy_q;

endmodule
